// File: rtl/fp_align_add.sv
// Pre-normalization stage of the binary32 adder: unpack, order by magnitude,
// align the smaller mantissa with an iterative right shifter, then add/subtract.
module fp_align_add #(
    parameter int SHIFT_PER_CYCLE = 4,
    parameter int MAX_DIFF        = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] aligned_result,
    output logic [7:0]  exponent_out,
    output logic        sticky_bit,
    output logic        aligned_sign,
    output logic        exp_overflow
);
    localparam int REM_W = $clog2(MAX_DIFF + 1);

    typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} state_t;

    state_t             state_reg, state_next;
    logic [23:0]        m_l_reg, m_l_next;
    logic [23:0]        m_s_reg, m_s_next;
    logic [7:0]         exp_l_reg, exp_l_next;
    logic               sign_l_reg, sign_l_next;
    logic               sign_s_reg, sign_s_next;
    logic [REM_W-1:0]   remaining_reg, remaining_next;
    logic               sticky_reg, sticky_next;
    logic [23:0]        result_reg, result_next;
    logic [7:0]         exp_out_reg, exp_out_next;
    logic               sticky_out_reg, sticky_out_next;
    logic               sign_out_reg, sign_out_next;
    logic               ovf_reg, ovf_next;

    // Operand unpack; a zero exponent flushes the operand to zero.
    logic [31:0] ops      [2];
    logic [7:0]  op_exp   [2];
    logic [23:0] op_man   [2];
    assign ops[0] = op_a;
    assign ops[1] = op_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign op_exp[gi] = ops[gi][30:23];
            assign op_man[gi] = (ops[gi][30:23] == 8'd0) ? 24'd0 : {1'b1, ops[gi][22:0]};
        end
    endgenerate

    logic             a_larger;
    logic [7:0]       exp_l_in, exp_s_in, diff;
    logic [REM_W-1:0] diff_clamped;
    assign a_larger     = {op_exp[0], op_man[0]} >= {op_exp[1], op_man[1]};
    assign exp_l_in     = a_larger ? op_exp[0] : op_exp[1];
    assign exp_s_in     = a_larger ? op_exp[1] : op_exp[0];
    assign diff         = exp_l_in - exp_s_in;
    assign diff_clamped = (diff > 8'(MAX_DIFF)) ? REM_W'(MAX_DIFF) : diff[REM_W-1:0];

    // Per-cycle alignment step and the bits it drops.
    logic [REM_W-1:0] amt;
    logic [23:0]      lost_mask;
    assign amt       = (remaining_reg > REM_W'(SHIFT_PER_CYCLE)) ? REM_W'(SHIFT_PER_CYCLE)
                                                                 : remaining_reg;
    assign lost_mask = ~(24'hFFFFFF << amt);

    logic        eff_sub;
    logic [24:0] sum;
    assign eff_sub = sign_l_reg ^ sign_s_reg;
    assign sum     = eff_sub ? ({1'b0, m_l_reg} - {1'b0, m_s_reg})
                             : ({1'b0, m_l_reg} + {1'b0, m_s_reg});

    always_comb begin
        state_next      = state_reg;
        m_l_next        = m_l_reg;
        m_s_next        = m_s_reg;
        exp_l_next      = exp_l_reg;
        sign_l_next     = sign_l_reg;
        sign_s_next     = sign_s_reg;
        remaining_next  = remaining_reg;
        sticky_next     = sticky_reg;
        result_next     = result_reg;
        exp_out_next    = exp_out_reg;
        sticky_out_next = sticky_out_reg;
        sign_out_next   = sign_out_reg;
        ovf_next        = ovf_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    m_l_next       = a_larger ? op_man[0] : op_man[1];
                    m_s_next       = a_larger ? op_man[1] : op_man[0];
                    exp_l_next     = exp_l_in;
                    sign_l_next    = a_larger ? op_a[31] : op_b[31];
                    sign_s_next    = a_larger ? op_b[31] : op_a[31];
                    remaining_next = diff_clamped;
                    sticky_next    = 1'b0;
                    state_next     = (diff_clamped != '0) ? ALIGN : ADD;
                end
            end
            ALIGN: begin
                m_s_next       = m_s_reg >> amt;
                sticky_next    = sticky_reg | (|(m_s_reg & lost_mask));
                remaining_next = remaining_reg - amt;
                if (remaining_reg == amt) state_next = ADD;
            end
            ADD: begin
                ovf_next = 1'b0;
                if (sum[24]) begin
                    result_next     = sum[24:1];
                    sticky_out_next = sticky_reg | sum[0];
                    if (exp_l_reg == 8'hFF) begin
                        exp_out_next = 8'hFF;
                        ovf_next     = 1'b1;
                    end else begin
                        exp_out_next = exp_l_reg + 8'd1;
                    end
                end else begin
                    result_next     = sum[23:0];
                    sticky_out_next = sticky_reg;
                    exp_out_next    = exp_l_reg;
                end
                sign_out_next = sign_l_reg;
                // Exact cancellation yields a canonical +0.
                if (sum == 25'd0) begin
                    sign_out_next   = 1'b0;
                    exp_out_next    = 8'd0;
                    sticky_out_next = 1'b0;
                end
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            m_l_reg        <= '0;
            m_s_reg        <= '0;
            exp_l_reg      <= '0;
            sign_l_reg     <= 1'b0;
            sign_s_reg     <= 1'b0;
            remaining_reg  <= '0;
            sticky_reg     <= 1'b0;
            result_reg     <= '0;
            exp_out_reg    <= '0;
            sticky_out_reg <= 1'b0;
            sign_out_reg   <= 1'b0;
            ovf_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            m_l_reg        <= m_l_next;
            m_s_reg        <= m_s_next;
            exp_l_reg      <= exp_l_next;
            sign_l_reg     <= sign_l_next;
            sign_s_reg     <= sign_s_next;
            remaining_reg  <= remaining_next;
            sticky_reg     <= sticky_next;
            result_reg     <= result_next;
            exp_out_reg    <= exp_out_next;
            sticky_out_reg <= sticky_out_next;
            sign_out_reg   <= sign_out_next;
            ovf_reg        <= ovf_next;
        end
    end

    assign in_ready       = (state_reg == IDLE);
    assign out_valid      = (state_reg == DONE);
    assign aligned_result = result_reg;
    assign exponent_out   = exp_out_reg;
    assign sticky_bit     = sticky_out_reg;
    assign aligned_sign   = sign_out_reg;
    assign exp_overflow   = ovf_reg;
endmodule

// File: tb/tb_fp_align_add.sv
// Scoreboard bench for fp_align_add: a one-shot alignment model predicts each
// result and its latency; the monitor compares when the DUT hands it over.
module tb_fp_align_add;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] op_a, op_b;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [23:0] aligned_result;
    logic [7:0]  exponent_out;
    logic        sticky_bit, aligned_sign, exp_overflow;

    fp_align_add #(.SHIFT_PER_CYCLE(4), .MAX_DIFF(26)) dut (
        .clk(clk), .reset(reset), .op_a(op_a), .op_b(op_b),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .aligned_result(aligned_result), .exponent_out(exponent_out),
        .sticky_bit(sticky_bit), .aligned_sign(aligned_sign),
        .exp_overflow(exp_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] res;
        logic [7:0]  e;
        logic        st, sg, ov;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        r;
        logic [7:0]  ea, eb, el, es;
        logic [23:0] ma, mb, ml, ms;
        logic        sl, ss, st;
        logic [47:0] wide;
        logic [24:0] s;
        int          d;
        ea = a[30:23]; eb = b[30:23];
        ma = (ea == 0) ? 24'd0 : {1'b1, a[22:0]};
        mb = (eb == 0) ? 24'd0 : {1'b1, b[22:0]};
        if ({eb, mb} > {ea, ma}) begin
            el = eb; ml = mb; sl = b[31]; es = ea; ms = ma; ss = a[31];
        end else begin
            el = ea; ml = ma; sl = a[31]; es = eb; ms = mb; ss = b[31];
        end
        d = int'(el) - int'(es);
        if (d > 26) d = 26;
        wide = {ms, 24'd0} >> d;
        st = |wide[23:0];
        s = (sl ^ ss) ? ({1'b0, ml} - {1'b0, wide[47:24]}) : ({1'b0, ml} + {1'b0, wide[47:24]});
        r.ov = 1'b0;
        r.sg = sl;
        if (s[24]) begin
            r.res = s[24:1];
            r.st  = st | s[0];
            r.e   = (el == 8'hFF) ? 8'hFF : el + 8'd1;
            r.ov  = (el == 8'hFF);
        end else begin
            r.res = s[23:0];
            r.st  = st;
            r.e   = el;
        end
        if (s == 0) begin
            r.sg = 1'b0; r.e = 8'd0; r.st = 1'b0;
        end
        r.lat = 2 + (d + 3) / 4;
        r.acc = 0;
        return r;
    endfunction

    // Monitor: latency on the rising edge of out_valid, fields on transfer.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && !prev_valid && sb.size() != 0)
                chk("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("aligned_result", 32'(aligned_result), 32'(e.res));
                    chk("exponent_out", 32'(exponent_out), 32'(e.e));
                    chk("sticky_bit", 32'(sticky_bit), 32'(e.st));
                    chk("aligned_sign", 32'(aligned_sign), 32'(e.sg));
                    chk("exp_overflow", 32'(exp_overflow), 32'(e.ov));
                    $display("txn res=0x%06h exp=%0d st=%0d sg=%0d ov=%0d", aligned_result,
                             exponent_out, sticky_bit, aligned_sign, exp_overflow);
                end
            end
        end
        prev_valid = out_valid;
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        exp_t m;
        int   n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        m = model(a, b);
        op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        m.acc = cyc;
        in_valid = 1'b0;
        sb.push_back(m);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_result"}, 32'(aligned_result), 32'd0);
        chk({tag, "_exp"}, 32'(exponent_out), 32'd0);
        chk({tag, "_sticky"}, 32'(sticky_bit), 32'd0);
        chk({tag, "_sign"}, 32'(aligned_sign), 32'd0);
        chk({tag, "_ovf"}, 32'(exp_overflow), 32'd0);
    endtask

    logic [31:0] vec_a [8] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                               32'h3F800000, 32'h7F800000, 32'h00000000, 32'hBFC00000};
    logic [31:0] vec_b [8] = '{32'h3F800000, 32'h3A800000, 32'hC0400000, 32'hBF800000,
                               32'h30800000, 32'h7F800000, 32'h3F800000, 32'h3F7FFFFF};

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Directed cases, including exponent saturation and a zero operand.
        for (int i = 0; i < 8; i++) begin
            send(vec_a[i], vec_b[i]);
            drain();
        end

        // Random operands with nearby exponents so every shift distance appears.
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a, b;
            a = {1'($urandom), 8'($urandom_range(100, 140)), 23'($urandom)};
            b = {1'($urandom), 8'($urandom_range(100, 140)), 23'($urandom)};
            if (i % 4 == 0) b = {~a[31], a[30:0]};
            send(a, b);
            drain();
        end

        // Backpressure: hold results in DONE while new operands are offered.
        out_ready = 1'b0;
        send(32'h40000000, 32'h3F000000);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!out_valid) chk("hold_valid_timeout", 32'd0, 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            op_a = 32'h12345678 + 32'(i); op_b = 32'h3F800000; in_valid = i[0];
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_result", 32'(aligned_result), 32'(sb[0].res));
            chk("hold_exp", 32'(exponent_out), 32'(sb[0].e));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (10) @(negedge clk);

        // Reset in the middle of a long alignment discards the operation.
        send(32'h3F800000, 32'h30800000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        check_reset_outputs("midreset");
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("post_reset_no_output", 32'(out_valid), 32'd0);

        send(32'h3F800000, 32'h3F800000);
        drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
